// File: rtl/key_scheduler.sv
// Round-key generator: 24-bit key state expanded one round per enabled clock, wrapping to the master key.
// Optional macro KEYSCHED_LOAD_EN adds LOAD/KEY_IN for run-time master-key loading.
module key_scheduler #(
   parameter logic [23:0] KEY_INIT   = 24'h3A94C7,
   parameter int          NUM_ROUNDS = 10
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        en,
`ifdef KEYSCHED_LOAD_EN
   input  logic        LOAD,
   input  logic [23:0] KEY_IN,
`endif
   output logic [7:0]  K_1,
   output logic [7:0]  K_2,
   output logic [7:0]  K_3,
   output logic [3:0]  ROUND,
   output logic        LAST
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   function automatic logic [3:0] sbox4(input logic [3:0] nib);
      case (nib)
         4'h0: sbox4 = 4'hC;
         4'h1: sbox4 = 4'h5;
         4'h2: sbox4 = 4'h6;
         4'h3: sbox4 = 4'hB;
         4'h4: sbox4 = 4'h9;
         4'h5: sbox4 = 4'h0;
         4'h6: sbox4 = 4'hA;
         4'h7: sbox4 = 4'hD;
         4'h8: sbox4 = 4'h3;
         4'h9: sbox4 = 4'hE;
         4'hA: sbox4 = 4'hF;
         4'hB: sbox4 = 4'h8;
         4'hC: sbox4 = 4'h4;
         4'hD: sbox4 = 4'h7;
         4'hE: sbox4 = 4'h1;
         4'hF: sbox4 = 4'h2;
         default: sbox4 = 4'h0;
      endcase
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd0: rcon = 8'h01;
         4'd1: rcon = 8'h02;
         4'd2: rcon = 8'h04;
         4'd3: rcon = 8'h08;
         4'd4: rcon = 8'h10;
         4'd5: rcon = 8'h20;
         4'd6: rcon = 8'h40;
         4'd7: rcon = 8'h80;
         4'd8: rcon = 8'h1B;
         4'd9: rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   logic [23:0] key_r;
   logic [3:0]  round_r;
   logic [23:0] master_s;
   logic [23:0] next_key_s;
   logic [3:0]  next_round_s;
   logic [7:0]  rot_s;
   logic [7:0]  t_s;
   logic [7:0]  w0_s;
   logic [7:0]  w1_s;
   logic [7:0]  w2_s;

`ifdef KEYSCHED_LOAD_EN
   logic [23:0] master_r;

   // Master-key register: captured on LOAD, source for the wrap reload.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         master_r <= KEY_INIT;
      end else if (LOAD) begin
         master_r <= KEY_IN;
      end else begin
         master_r <= master_r;
      end
   end

   assign master_s = master_r;
`else
   assign master_s = KEY_INIT;
`endif

   // One expansion round: rotate w2, substitute nibbles, add round constant, chain XORs.
   always_comb begin
      rot_s = {key_r[4:0], key_r[7:5]};
      t_s   = {sbox4(rot_s[7:4]), sbox4(rot_s[3:0])} ^ rcon(round_r);
      w0_s  = key_r[23:16] ^ t_s;
      w1_s  = key_r[15:8] ^ w0_s;
      w2_s  = key_r[7:0] ^ w1_s;
   end

   // Next-state selection: load beats en; the final round wraps instead of transforming.
   always_comb begin
      next_key_s   = key_r;
      next_round_s = round_r;
`ifdef KEYSCHED_LOAD_EN
      if (LOAD) begin
         next_key_s   = KEY_IN;
         next_round_s = 4'd0;
      end else
`endif
      if (en) begin
         if (round_r == LAST_ROUND) begin
            next_key_s   = master_s;
            next_round_s = 4'd0;
         end else begin
            next_key_s   = {w0_s, w1_s, w2_s};
            next_round_s = round_r + 4'd1;
         end
      end else begin
         next_key_s   = key_r;
         next_round_s = round_r;
      end
   end

   // Key state and round counter registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         key_r   <= KEY_INIT;
         round_r <= 4'd0;
      end else begin
         key_r   <= next_key_s;
         round_r <= next_round_s;
      end
   end

   assign K_1   = key_r[23:16];
   assign K_2   = key_r[15:8];
   assign K_3   = key_r[7:0];
   assign ROUND = round_r;
   assign LAST  = (round_r == LAST_ROUND);

endmodule

// File: tb/tb_key_scheduler.sv
// Self-checking bench for key_scheduler: byte-level reference model plus directed and random stimulus.
module tb_key_scheduler;

   localparam logic [23:0] KEY_INIT   = 24'h3A94C7;
   localparam int          NUM_ROUNDS = 10;
   localparam int SBOX_T [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
   localparam int RCON_T [10] = '{1, 2, 4, 8, 16, 32, 64, 128, 27, 54};

   logic        CLK;
   logic        RST_N;
   logic        en;
   logic        load;
   logic [23:0] key_in;
   logic [7:0]  K_1, K_2, K_3;
   logic [3:0]  ROUND;
   logic        LAST;

   int          n_tests;
   int          n_fail;
   logic        chk_on;

   logic [23:0] m_state;
   logic [23:0] m_master;
   int          m_round;

   key_scheduler #(.KEY_INIT(KEY_INIT), .NUM_ROUNDS(NUM_ROUNDS)) dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .en     (en),
`ifdef KEYSCHED_LOAD_EN
      .LOAD   (load),
      .KEY_IN (key_in),
`endif
      .K_1    (K_1),
      .K_2    (K_2),
      .K_3    (K_3),
      .ROUND  (ROUND),
      .LAST   (LAST)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [23:0] model_step(input logic [23:0] st, input int rnd);
      int w0, w1, w2, r, s;
      w0 = int'(st[23:16]);
      w1 = int'(st[15:8]);
      w2 = int'(st[7:0]);
      r  = ((w2 * 8) + (w2 / 32)) % 256;
      s  = SBOX_T[r / 16] * 16 + SBOX_T[r % 16];
      w0 = w0 ^ (s ^ RCON_T[rnd]);
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      return {w0[7:0], w1[7:0], w2[7:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model of the schedule
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_state  <= KEY_INIT;
         m_master <= KEY_INIT;
         m_round  <= 0;
      end else if (load) begin
         m_state  <= key_in;
         m_master <= key_in;
         m_round  <= 0;
      end else if (en) begin
         if (m_round == NUM_ROUNDS) begin
            m_state <= m_master;
            m_round <= 0;
         end else begin
            m_state <= model_step(m_state, m_round);
            m_round <= m_round + 1;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge CLK) begin
      if (chk_on) begin
         check("key", {8'h00, K_1, K_2, K_3}, {8'h00, m_state});
         check("round", 32'(ROUND), 32'(m_round));
         check("last", 32'(LAST), 32'(m_round == NUM_ROUNDS));
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      chk_on  = 1'b0;
      RST_N   = 1'b1;
      en      = 1'b0;
      load    = 1'b0;
      key_in  = 24'h000000;
      #1 RST_N = 1'b0;

      @(negedge CLK);
      check("reset_key", {8'h00, K_1, K_2, K_3}, 32'h003A94C7);
      check("reset_round", 32'(ROUND), 32'd0);
      check("reset_last", 32'(LAST), 32'd0);
      chk_on = 1'b1;
      @(posedge CLK);
      #2 RST_N = 1'b1;

      // single round from the master key
      @(negedge CLK);
      en = 1'b1;
      @(posedge CLK);
      #1;
      check("round1_key", {8'h00, K_1, K_2, K_3}, 32'h008A1ED9);
      check("round1_round", 32'(ROUND), 32'd1);
      check("model_pin_round1", {8'h00, m_state}, 32'h008A1ED9);

      // hold with en low
      @(negedge CLK);
      en = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      check("hold_key", {8'h00, K_1, K_2, K_3}, 32'h008A1ED9);
      check("hold_round", 32'(ROUND), 32'd1);

      // asynchronous reset mid-run with en high
      @(negedge CLK);
      en = 1'b1;
      @(posedge CLK);
      #2 RST_N = 1'b0;
      #1;
      check("async_rst_key", {8'h00, K_1, K_2, K_3}, 32'h003A94C7);
      check("async_rst_round", 32'(ROUND), 32'd0);
      check("async_rst_last", 32'(LAST), 32'd0);
      @(negedge CLK);
      #1 RST_N = 1'b1;

      // full sequence of rounds then wrap
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
         @(posedge CLK);
         #1;
         check("seq_round", 32'(ROUND), 32'(i));
         check("seq_last", 32'(LAST), 32'(i == NUM_ROUNDS));
      end
      @(posedge CLK);
      #1;
      check("wrap_key", {8'h00, K_1, K_2, K_3}, 32'h003A94C7);
      check("wrap_round", 32'(ROUND), 32'd0);
      check("wrap_last", 32'(LAST), 32'd0);

      // randomized traffic with occasional resets (and loads when enabled)
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         en = ($urandom_range(0, 3) != 0);
`ifdef KEYSCHED_LOAD_EN
         load   = ($urandom_range(0, 15) == 0);
         key_in = 24'($urandom);
`endif
         if (!RST_N) begin
            #2 RST_N = 1'b1;
         end else if ($urandom_range(0, 39) == 0) begin
            #2 RST_N = 1'b0;
         end
      end
      @(negedge CLK);
      en   = 1'b0;
      load = 1'b0;
      if (!RST_N) begin
         #2 RST_N = 1'b1;
      end

`ifdef KEYSCHED_LOAD_EN
      @(negedge CLK);
      load   = 1'b1;
      key_in = 24'h000000;
      en     = 1'b1;
      @(posedge CLK);
      #1;
      check("load_key", {8'h00, K_1, K_2, K_3}, 32'h00000000);
      check("load_round", 32'(ROUND), 32'd0);
      @(negedge CLK);
      load = 1'b0;
      @(posedge CLK);
      #1;
      check("load_step_key", {8'h00, K_1, K_2, K_3}, 32'h00CDCDCD);
      repeat (NUM_ROUNDS) @(posedge CLK);
      #1;
      check("load_wrap_key", {8'h00, K_1, K_2, K_3}, 32'h00000000);
      check("load_wrap_round", 32'(ROUND), 32'd0);
      @(negedge CLK);
      en = 1'b0;
`endif

      repeat (2) @(posedge CLK);
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
